intersection_cmd_sequencer: RTL and testbench

- Upstream stage of the intersection simulator.
- Accepts car add/remove and blacklist-display requests over a valid/ready interface and buffers them in a FIFO.
- Replays each request as a stable mode/plateIn pair plus a clean, timed action pulse, which is what the simulator's posedge-action logic consumes.
- Filters zero plates on add requests and serialises display mode so it never interrupts a car transaction.

---
 rtl/intersection_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_intersection_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intersection_cmd_sequencer: FIFO-buffered car/display requests replayed as |
// | stable mode/plate plus a timed action pulse.              Rev 1.0          |
// +----------------------------------------------------------------------------+
module intersection_cmd_sequencer #(
  parameter int DEPTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [4:0] req_plate,
  input  logic       disp_req,
  output logic [2:0] mode,
  output logic [4:0] plate_out,
  output logic       action,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic [7:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] c_depth    = 5'(DEPTH);
  localparam logic [3:0] c_setup_ld = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_pulse_ld = 4'(PULSE_CYC - 1);
  localparam logic [3:0] c_gap_ld   = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DISP  = 3'd4
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [2:0]      r_mode;
  logic [4:0]      r_plate;
  logic            r_action;
  logic [7:0]      r_drop;
  logic [4:0]      r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [6:0]      r_mem [DEPTH];

  logic            w_take;
  logic            w_zero_add;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic [6:0]      w_head;

  assign req_ready  = rst_n && (r_count < c_depth);
  assign w_take     = req_valid && req_ready;
  assign w_zero_add = req_op[1] && (req_plate == 5'd0);
  assign w_push     = w_take && !w_zero_add;
  assign w_drop     = w_take && w_zero_add;
  assign w_pop      = (r_state == S_IDLE) && !disp_req && (r_count != 5'd0);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_op, req_plate};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
      r_drop   <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_mode   <= 3'b000;
      r_plate  <= 5'd0;
      r_action <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (disp_req) begin
            r_state <= S_DISP;
            r_mode  <= 3'b100;
            r_plate <= 5'd0;
          end else if (r_count != 5'd0) begin
            r_state <= S_SETUP;
            r_mode  <= {1'b0, w_head[6:5]};
            r_plate <= w_head[6] ? w_head[4:0] : 5'd0;
            r_cnt   <= c_setup_ld;
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_PULSE;
            r_action <= 1'b1;
            r_cnt    <= c_pulse_ld;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_PULSE: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_GAP;
            r_action <= 1'b0;
            r_cnt    <= c_gap_ld;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DISP: begin
          if (!disp_req) begin
            r_state <= S_IDLE;
            r_mode  <= 3'b000;
            r_plate <= 5'd0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_action <= 1'b0;
        end
      endcase
    end
  end

  assign mode       = r_mode;
  assign plate_out  = r_plate;
  assign action     = r_action;
  assign busy       = (r_state != S_IDLE);
  assign drop_count = r_drop;
  // A full 16-deep FIFO cannot be shown in four bits, so it reads as 15.
  assign fifo_count = r_count[4] ? 4'hF : r_count[3:0];

endmodule
`default_nettype wire

// File: tb/tb_intersection_cmd_sequencer.sv
`default_nettype none
// Bench for intersection_cmd_sequencer: timestamped transaction model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_intersection_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int S     = 1;
  localparam int P     = 2;
  localparam int G     = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [4:0] req_plate = 5'd0;
  logic       disp_req = 1'b0;
  logic [2:0] mode;
  logic [4:0] plate_out;
  logic       action;
  logic       busy;
  logic [3:0] fifo_count;
  logic [7:0] drop_count;

  intersection_cmd_sequencer #(
    .DEPTH(DEPTH), .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_plate(req_plate), .disp_req(disp_req),
    .mode(mode), .plate_out(plate_out), .action(action), .busy(busy),
    .fifo_count(fifo_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: pending requests in a queue; an issued transaction is a start
  // timestamp, and the outputs are derived from elapsed edges since it.
  logic [6:0] q[$];
  int         cyc      = 0;
  int         t0       = 0;
  bit         active   = 1'b0;
  bit         m_disp   = 1'b0;
  int         m_drop   = 0;
  int         m_mode   = 0;
  int         m_plate  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0; t0 = 0; active = 0; m_disp = 0;
      m_drop = 0; m_mode = 0; m_plate = 0;
    end else begin
      int  size_before;
      bit  was_idle;
      logic [6:0] e;
      cyc++;
      size_before = q.size();
      was_idle = !active && !m_disp;
      if (active && (cyc - t0 == S + P + G)) begin
        active = 0;
      end else if (m_disp && !disp_req) begin
        m_disp = 0; m_mode = 0; m_plate = 0;
      end else if (was_idle) begin
        if (disp_req) begin
          m_disp = 1; m_mode = 4; m_plate = 0;
        end else if (q.size() > 0) begin
          e = q.pop_front();
          m_mode  = int'(e[6:5]);
          m_plate = e[6] ? int'(e[4:0]) : 0;
          active  = 1; t0 = cyc;
        end
      end
      if (req_valid && (size_before < DEPTH)) begin
        if (req_op[1] && (req_plate == 5'd0)) begin
          if (m_drop < 255) m_drop++;
        end else begin
          q.push_back({req_op, req_plate});
        end
      end
    end
  end

  function automatic int m_action();
    return (active && (cyc - t0 >= S) && (cyc - t0 < S + P)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready",  int'(req_ready),  (rst_n && q.size() < DEPTH) ? 1 : 0);
      chk("fifo_count", int'(fifo_count), q.size());
      chk("drop_count", int'(drop_count), m_drop);
      chk("mode",       int'(mode),       m_mode);
      chk("plate_out",  int'(plate_out),  m_plate);
      chk("action",     int'(action),     m_action());
      chk("busy",       int'(busy),       (active || m_disp) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sum;
    int rises[$];
    bit prev;

    repeat (2) tick();
    chk("reset_action", int'(action), 0);
    chk("reset_ready",  int'(req_ready), 0);
    chk("reset_mode",   int'(mode), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Single addA plate 5 into an empty FIFO.
    req_valid = 1; req_op = 2'b10; req_plate = 5'd5;
    tick();
    req_valid = 0;
    chk("t0_count", int'(fifo_count), 1);
    tick();
    chk("t1_mode", int'(mode), 3'b010);
    chk("t1_plate", int'(plate_out), 5);
    chk("t1_action", int'(action), 0);
    tick(); chk("t2_action", int'(action), 1);
    tick(); chk("t3_action", int'(action), 1);
    tick(); chk("t4_action", int'(action), 0);
    tick(); chk("t5_busy", int'(busy), 1);
    tick(); chk("t6_busy", int'(busy), 0);
    chk("t6_count", int'(fifo_count), 0);

    // Zero-plate addB is dropped, remB issues with plate forced to 0.
    req_valid = 1; req_op = 2'b11; req_plate = 5'd0;
    tick();
    req_op = 2'b01; req_plate = 5'd9;
    tick();
    req_valid = 0;
    chk("drop_one", int'(drop_count), 1);
    chk("rem_count", int'(fifo_count), 1);
    tick();
    chk("rem_mode", int'(mode), 3'b001);
    chk("rem_plate", int'(plate_out), 0);
    sum = 0;
    for (int i = 0; i < 8; i++) begin tick(); sum += int'(action); end
    chk("rem_pulse_width", sum, P);
    chk("rem_busy_end", int'(busy), 0);

    // Fill during display mode, then drain.
    disp_req = 1;
    tick();
    chk("disp_mode", int'(mode), 3'b100);
    req_valid = 1;
    for (int i = 0; i < 12; i++) begin
      req_op = 2'($urandom_range(0, 3));
      req_plate = 5'($urandom_range(1, 31));
      tick();
      chk("disp_no_action", int'(action), 0);
    end
    chk("full_count", int'(fifo_count), 8);
    chk("full_ready", int'(req_ready), 0);
    req_valid = 0; disp_req = 0;
    tick();
    chk("disp_exit_mode", int'(mode), 3'b000);
    prev = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (action && !prev) rises.push_back(i);
      prev = action;
    end
    chk("drain_pulses", rises.size(), 8);
    for (int i = 1; i < rises.size(); i++) chk("drain_spacing", rises[i] - rises[i-1], 6);
    chk("drain_empty", int'(fifo_count), 0);

    // Display requested mid-pulse is deferred until the transaction ends.
    req_valid = 1; req_op = 2'b00; req_plate = 5'd7;
    tick();
    req_valid = 0;
    tick(); chk("rema_mode", int'(mode), 0);
    tick(); chk("rema_pulse", int'(action), 1);
    disp_req = 1;
    tick(); chk("defer_pulse", int'(action), 1);
    tick(); chk("defer_fall", int'(action), 0);
    tick(); chk("defer_gap_busy", int'(busy), 1);
    tick(); chk("defer_idle", int'(busy), 0);
    chk("defer_idle_mode", int'(mode), 0);
    tick(); chk("defer_disp_mode", int'(mode), 3'b100);
    repeat (5) tick();
    disp_req = 0;
    tick(); chk("defer_exit_busy", int'(busy), 0);

    // Asynchronous reset during a pulse.
    req_valid = 1; req_op = 2'b10; req_plate = 5'd3;
    tick();
    req_valid = 0;
    tick();
    tick(); chk("pre_rst_action", int'(action), 1);
    rst_n = 0;
    #1;
    chk("async_action", int'(action), 0);
    chk("async_count", int'(fifo_count), 0);
    chk("async_drop", int'(drop_count), 0);
    chk("async_ready", int'(req_ready), 0);
    tick(); tick();
    rst_n = 1;
    sum = 0;
    for (int i = 0; i < 20; i++) begin tick(); sum += int'(action); end
    chk("post_rst_quiet", sum, 0);

    // Randomized traffic with occasional display requests.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_op = 2'($urandom_range(0, 3));
      req_plate = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 15) == 0) disp_req = ~disp_req;
      tick();
    end
    req_valid = 0; disp_req = 0;
    repeat (80) tick();
    chk("rand_drained", int'(fifo_count), 0);

    // drop_count saturation.
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    req_valid = 1; req_plate = 5'd0;
    for (int i = 0; i < 255; i++) begin
      req_op = $urandom_range(0, 1) ? 2'b10 : 2'b11;
      tick();
    end
    chk("drop_255", int'(drop_count), 255);
    chk("drop_empty", int'(fifo_count), 0);
    repeat (3) tick();
    req_valid = 0;
    chk("drop_sat", int'(drop_count), 255);
    chk("drop_still_empty", int'(fifo_count), 0);
    tick();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
